// File: rtl/c64_keys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c64_keys_pkg
// Description : Shared definitions for the C64 keyboard event path.
//               Covers the matrix size, the event byte layout, an event
//               builder, and the key index map used by the menu firmware.
// Revision    : 1.0 - initial release
// ============================================================================
package c64_keys_pkg;

    localparam int C64_NUM_KEYS      = 64;
    localparam int KEY_EVT_BREAK_BIT = 7;

    // Event byte: bit 7 = break (1) / make (0), bit 6 reserved (0), 5:0 key index
    typedef struct packed {
        logic       brk;
        logic       rsvd;
        logic [5:0] idx;
    } key_evt_t;

    // Key index map as seen by the firmware (row*8 + column of the matrix)
    localparam logic [5:0] KEY_IDX_DEL     = 6'd0;
    localparam logic [5:0] KEY_IDX_RETURN  = 6'd1;
    localparam logic [5:0] KEY_IDX_CRSR_LR = 6'd2;
    localparam logic [5:0] KEY_IDX_F7      = 6'd3;
    localparam logic [5:0] KEY_IDX_F1      = 6'd4;
    localparam logic [5:0] KEY_IDX_F3      = 6'd5;
    localparam logic [5:0] KEY_IDX_F5      = 6'd6;
    localparam logic [5:0] KEY_IDX_CRSR_UD = 6'd7;
    localparam logic [5:0] KEY_IDX_SPACE   = 6'd60;
    localparam logic [5:0] KEY_IDX_RUNSTOP = 6'd63;  // menu key

    // A released level (1) on the active-low matrix yields a break event
    function automatic key_evt_t make_key_evt(input logic released, input logic [5:0] idx);
        logic [7:0] v;
        v                    = '0;
        v[KEY_EVT_BREAK_BIT] = released;
        v[5:0]               = idx;
        return key_evt_t'(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : key_evt_fifo
// Description : Generic synchronous circular-buffer FIFO.
//               Ports: clk, rst (sync, active-high), i_push/i_wdata,
//               i_pop, o_rdata (head, combinational, 0 when empty),
//               o_full, o_empty, o_count.
//               A push while full is refused even with a simultaneous pop;
//               a pop while empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module key_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
    localparam logic [c_PTR_W:0]   c_CNT_ONE = 1;
    localparam logic [c_PTR_W:0]   c_CNT_MAX = DEPTH[c_PTR_W:0];

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr;
    logic [c_PTR_W-1:0] r_rd;
    logic [c_PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_CNT_MAX);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    // Fullness is judged on the pre-pop count
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;
    // Gate the head so stale storage never shows after reset or draining
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= r_wr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd <= r_rd + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/c64_key_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : c64_key_event_queue
// Description : Scans the 64-key C64 matrix one key per SCAN_DIV cycles.
//               A level change must be seen on two consecutive passes to
//               be accepted, and accepted changes are queued as make/break
//               events.
//               Ports: sysclk, reset (sync, active-high), enable, keys
//               (active-low matrix), evt_data/evt_valid/evt_ack/evt_count
//               (event queue head and pop), overflow/clr_overflow (sticky
//               refused-event flag).
// Revision    : 1.0 - initial release
// ============================================================================
module c64_key_event_queue
    import c64_keys_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SCAN_DIV   = 16
) (
    input  logic                        sysclk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [63:0]                 keys,
    output logic [7:0]                  evt_data,
    output logic                        evt_valid,
    input  logic                        evt_ack,
    output logic [$clog2(FIFO_DEPTH):0] evt_count,
    output logic                        overflow,
    input  logic                        clr_overflow
);

    localparam logic [7:0] c_DIV_LAST = 8'(SCAN_DIV - 1);

    logic [C64_NUM_KEYS-1:0] r_keys;
    logic [C64_NUM_KEYS-1:0] r_stable;
    logic [C64_NUM_KEYS-1:0] r_pend;
    logic [7:0]              r_div;
    logic [5:0]              r_idx;
    logic                    r_overflow;

    logic     w_slot;
    logic     w_key;
    logic     w_diff;
    logic     w_commit;
    logic     w_push;
    logic     w_refuse;
    logic     w_full;
    logic     w_empty;
    key_evt_t w_evt;

    assign w_slot   = enable && (r_div == c_DIV_LAST);
    assign w_key    = r_keys[r_idx];
    assign w_diff   = (w_key != r_stable[r_idx]);
    // Second consecutive sighting of the same difference
    assign w_commit = w_slot & w_diff & r_pend[r_idx];
    assign w_push   = w_commit & ~w_full;
    assign w_refuse = w_commit &  w_full;
    assign w_evt    = make_key_evt(w_key, r_idx);

    assign evt_valid = ~w_empty;
    assign overflow  = r_overflow;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_keys <= '1;
        end else begin
            r_keys <= keys;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (enable) begin
            if (r_div == c_DIV_LAST) begin
                r_div <= '0;
                r_idx <= r_idx + 6'd1;  // wraps 63 -> 0
            end else begin
                r_div <= r_div + 8'd1;
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_stable <= '1;
            r_pend   <= '0;
        end else if (w_slot) begin
            if (!w_diff) begin
                r_pend[r_idx] <= 1'b0;
            end else if (!r_pend[r_idx]) begin
                r_pend[r_idx] <= 1'b1;
            end else if (!w_full) begin
                r_stable[r_idx] <= w_key;
                r_pend[r_idx]   <= 1'b0;
            end
            // Refused commit: stable and pend untouched so the next pass retries
        end
    end

    // Set wins over clear in the same cycle
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_refuse) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    key_evt_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sysclk),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (w_evt),
        .i_pop   (evt_ack),
        .o_rdata (evt_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (evt_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_c64_key_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_c64_key_event_queue
// Description : Self-checking bench for c64_key_event_queue. Directed
//               scenarios plus a randomized run against a queue-based
//               reference model driven by the scan-slot arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c64_key_event_queue;

    localparam int DEPTH  = 8;
    localparam int SDIV   = 16;
    localparam int PERIOD = 64 * SDIV;
    localparam int LAT    = 1 + 2 * PERIOD + 1;

    logic                     sysclk = 1'b0;
    logic                     reset = 1'b1;
    logic                     enable = 1'b1;
    logic [63:0]              keys = '1;
    logic [7:0]               evt_data;
    logic                     evt_valid;
    logic                     evt_ack = 1'b0;
    logic [$clog2(DEPTH):0]   evt_count;
    logic                     overflow;
    logic                     clr_overflow = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    c64_key_event_queue #(.FIFO_DEPTH(DEPTH), .SCAN_DIV(SDIV)) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .enable       (enable),
        .keys         (keys),
        .evt_data     (evt_data),
        .evt_valid    (evt_valid),
        .evt_ack      (evt_ack),
        .evt_count    (evt_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // ---------------- reference model ----------------
    // m_tick counts enabled cycles since reset: the slot and key index
    // follow directly from it by division.
    bit          m_stable [64];
    bit          m_pend   [64];
    logic [63:0] m_keys;
    int          m_tick;
    logic [7:0]  m_q [$];
    bit          m_ovf;

    always @(posedge sysclk) begin : ref_model
        int idx;
        bit slot, full, do_pop, set_ovf, key;
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                m_stable[i] = 1'b1;
                m_pend[i]   = 1'b0;
            end
            m_q.delete();
            m_ovf  = 1'b0;
            m_keys = '1;
            m_tick = 0;
        end else begin
            slot    = enable && ((m_tick % SDIV) == SDIV - 1);
            idx     = (m_tick / SDIV) % 64;
            full    = (m_q.size() == DEPTH);
            do_pop  = evt_ack && (m_q.size() != 0);
            set_ovf = 1'b0;
            if (do_pop) void'(m_q.pop_front());
            if (slot) begin
                key = m_keys[idx];
                if (key == m_stable[idx]) m_pend[idx] = 1'b0;
                else if (!m_pend[idx])    m_pend[idx] = 1'b1;
                else if (full)            set_ovf = 1'b1;
                else begin
                    m_q.push_back({key, 1'b0, 6'(idx)});
                    m_stable[idx] = key;
                    m_pend[idx]   = 1'b0;
                end
            end
            if (set_ovf)           m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
            m_keys = keys;
            if (enable) m_tick++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1; keys = '1; evt_ack = 1'b0; clr_overflow = 1'b0; enable = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic pop_one();
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
    endtask

    task automatic wait_count(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (evt_count == target) ok = 1'b1;
            else tick(1);
        end
        if (evt_count == target) ok = 1'b1;
    endtask

    task automatic wait_ovf(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (overflow) ok = 1'b1;
            else tick(1);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit seen;
        tick(1);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", evt_valid); end
        checks++; if (evt_count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", evt_count); end
        checks++; if (evt_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", evt_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            tick(1);
            if (evt_valid !== 1'b0 || evt_count !== 0 || overflow !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL idle_quiet got activity want none"); end
    endtask

    task automatic test_press_release();
        bit ok;
        do_reset();
        keys[5] = 1'b0;
        wait_count(1, LAT + 2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL make5_timeout got count %0d want 1", evt_count); end
        checks++; if (evt_data !== 8'h05) begin errors++; $display("FAIL make5_data got %h want 05", evt_data); end
        tick(2 * PERIOD);
        checks++; if (evt_count !== 1) begin errors++; $display("FAIL make5_once got %0d want 1", evt_count); end
        keys[5] = 1'b1;
        wait_count(2, LAT + 2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL break5_timeout got count %0d want 2", evt_count); end
        pop_one();
        checks++; if (evt_count !== 1 || evt_data !== 8'h85) begin
            errors++; $display("FAIL pop1 got count %0d data %h want 1 85", evt_count, evt_data); end
        pop_one();
        checks++; if (evt_count !== 0 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL pop2 got count %0d valid %b want 0 0", evt_count, evt_valid); end
    endtask

    task automatic test_glitch();
        bit seen;
        do_reset();
        seen = 1'b0;
        keys[20] = 1'b0;
        tick(300);
        keys[20] = 1'b1;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            tick(1);
            if (evt_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL glitch got event %h want none", evt_data); end
    endtask

    task automatic test_overflow();
        bit ok;
        do_reset();
        keys[9:0] = '0;
        wait_ovf(LAT + 2 * SDIV * 10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got %b want 1", overflow); end
        tick(4 * SDIV);  // let key 9 also be refused so retries arrive in index order
        checks++; if (evt_count !== DEPTH) begin errors++; $display("FAIL ovf_count got %0d want %0d", evt_count, DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (evt_data !== 8'(i)) begin errors++; $display("FAIL ovf_entry%0d got %h want %h", i, evt_data, 8'(i)); end
            pop_one();
        end
        wait_count(2, LAT, ok);
        checks++; if (!ok) begin errors++; $display("FAIL retry_timeout got count %0d want 2", evt_count); end
        checks++; if (evt_data !== 8'h08) begin errors++; $display("FAIL retry8 got %h want 08", evt_data); end
        pop_one();
        checks++; if (evt_data !== 8'h09) begin errors++; $display("FAIL retry9 got %h want 09", evt_data); end
        pop_one();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_back_to_back();
        bit ok, hit;
        logic [7:0] exp_order [4];
        do_reset();
        keys[3:0] = '0;
        keys[10]  = 1'b0;
        wait_count(4, LAT + 8 * SDIV, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_fill got count %0d want 4", evt_count); end
        hit = 1'b0;
        for (int i = 0; i < 2 * PERIOD && !hit; i++) begin
            if ((m_tick % SDIV) == SDIV - 1 && ((m_tick / SDIV) % 64) == 10 && m_pend[10]) begin
                pop_one();
                hit = 1'b1;
            end else tick(1);
        end
        checks++; if (!hit) begin errors++; $display("FAIL b2b_slot_timeout got none want slot10"); end
        checks++; if (evt_count !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", evt_count); end
        exp_order = '{8'h01, 8'h02, 8'h03, 8'h0A};
        for (int i = 0; i < 4; i++) begin
            checks++; if (evt_data !== exp_order[i]) begin
                errors++; $display("FAIL b2b_order%0d got %h want %h", i, evt_data, exp_order[i]); end
            pop_one();
        end
        evt_ack = 1'b1;
        tick(3);
        evt_ack = 1'b0;
        checks++; if (evt_count !== 0 || evt_valid !== 1'b0) begin
            errors++; $display("FAIL empty_ack got count %0d valid %b want 0 0", evt_count, evt_valid); end
        keys[0] = 1'b1;
        wait_count(1, LAT + 2, ok);
        checks++; if (!ok || evt_data !== 8'h80) begin
            errors++; $display("FAIL empty_ack_ptr got count %0d data %h want 1 80", evt_count, evt_data); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        keys[2:0] = '0;
        keys[63]  = 1'b0;
        wait_count(3, LAT + 4 * SDIV, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_fill got count %0d want 3", evt_count); end
        reset = 1'b1;
        keys[2:0] = '1;
        evt_ack = 1'b1;
        tick(1);
        evt_ack = 1'b0;
        reset = 1'b0;
        checks++; if (evt_count !== 0 || evt_valid !== 1'b0 || overflow !== 1'b0 || evt_data !== 8'h00) begin
            errors++; $display("FAIL mid_reset got count %0d valid %b ovf %b data %h want 0 0 0 00",
                               evt_count, evt_valid, overflow, evt_data); end
        wait_count(1, LAT, ok);
        checks++; if (!ok || evt_data !== 8'h3F) begin
            errors++; $display("FAIL runstop got count %0d data %h want 1 3f", evt_count, evt_data); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 20000; c++) begin
            tick(1);
            checks++; if (evt_count !== m_q.size()) begin
                errors++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, evt_count, m_q.size()); end
            checks++; if (evt_valid !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, evt_valid, m_q.size() != 0); end
            checks++; if (overflow !== m_ovf) begin
                errors++; $display("FAIL rnd_ovf cyc %0d got %b want %b", c, overflow, m_ovf); end
            if (m_q.size() != 0) begin
                checks++; if (evt_data !== m_q[0]) begin
                    errors++; $display("FAIL rnd_data cyc %0d got %h want %h", c, evt_data, m_q[0]); end
            end
            if ($urandom_range(0, 59) == 0) keys[$urandom_range(0, 63)] ^= 1'b1;
            evt_ack      = ($urandom_range(0, 29) == 0);
            clr_overflow = ($urandom_range(0, 399) == 0);
            enable       = ($urandom_range(0, 9) != 0);
            reset        = ($urandom_range(0, 7999) == 0);
        end
        reset = 1'b0; evt_ack = 1'b0; clr_overflow = 1'b0; enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
